// File: rtl/random_delay_requester_if.sv
// rtl/random_delay_requester_if.sv - random-delay requester handshake and status bundle
interface random_delay_requester_if;
    logic       ena;
    logic       req;
    logic       cancel;
    logic [7:0] rnd_value;
    logic       rnd_rdy;
    logic       rnd_start;
    logic [7:0] captured;
    logic       busy;
    logic       delay_done;
    logic       err;

    modport master (
        output ena, req, cancel, rnd_value, rnd_rdy,
        input  rnd_start, captured, busy, delay_done, err
    );

    modport slave (
        input  ena, req, cancel, rnd_value, rnd_rdy,
        output rnd_start, captured, busy, delay_done, err
    );
endinterface

// File: rtl/random_delay_requester.sv
// rtl/random_delay_requester.sv - requests a random value and turns it into a randomized tick delay
module random_delay_requester #(
    parameter int MIN_DELAY = 16,
    parameter int SHIFT     = 0,
    parameter int TIMEOUT   = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    random_delay_requester_if.slave   bus_if
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_WAIT_RDY = 3'd2;
    localparam logic [2:0] S_DELAY    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_rnd_start;
    logic        w_rnd_start_nxt;
    logic [7:0]  r_captured;
    logic [7:0]  w_captured_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [7:0]  r_tcnt;
    logic [7:0]  w_tcnt_nxt;

    logic [15:0] w_load;
    logic [7:0]  w_tcnt_inc;
    logic        w_timeout;
    logic        w_handshake;

    assign w_load      = (16'(bus_if.rnd_value) << SHIFT) + 16'(MIN_DELAY);
    assign w_tcnt_inc  = r_tcnt + 8'd1;
    assign w_handshake = (r_state == S_ARM) || (r_state == S_WAIT_RDY);
    assign w_timeout   = w_handshake && bus_if.ena && (w_tcnt_inc == 8'(TIMEOUT));

    always_comb begin
        w_state_nxt     = r_state;
        w_rnd_start_nxt = r_rnd_start;
        w_captured_nxt  = r_captured;
        w_err_nxt       = r_err;
        w_cnt_nxt       = r_cnt;
        w_tcnt_nxt      = r_tcnt;

        if (w_handshake && bus_if.ena) begin
            w_tcnt_nxt = w_tcnt_inc;
        end

        case (r_state)
            S_IDLE: begin
                if (bus_if.req) begin
                    w_state_nxt     = S_ARM;
                    w_rnd_start_nxt = 1'b1;
                    w_err_nxt       = 1'b0;
                    w_tcnt_nxt      = 8'd0;
                end
            end
            S_ARM: begin
                // A ready flag still high here belongs to the previous run; wait for it to clear.
                if (w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_rnd_start_nxt = 1'b0;
                    w_err_nxt       = 1'b1;
                end else if (!bus_if.rnd_rdy) begin
                    w_state_nxt = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (bus_if.rnd_rdy) begin
                    // Dropping start on the capture edge freezes the generator output.
                    w_captured_nxt  = bus_if.rnd_value;
                    w_rnd_start_nxt = 1'b0;
                    w_cnt_nxt       = w_load;
                    w_state_nxt     = (w_load == 16'd0) ? S_DONE : S_DELAY;
                end else if (w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_rnd_start_nxt = 1'b0;
                    w_err_nxt       = 1'b1;
                end
            end
            S_DELAY: begin
                if (bus_if.ena) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                    if (r_cnt == 16'd1) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_rnd_start_nxt = 1'b0;
            end
        endcase

        if (bus_if.cancel) begin
            w_state_nxt     = S_IDLE;
            w_rnd_start_nxt = 1'b0;
            w_captured_nxt  = r_captured;
            w_err_nxt       = r_err;
            w_cnt_nxt       = 16'd0;
            w_tcnt_nxt      = r_tcnt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_rnd_start <= 1'b0;
            r_captured  <= 8'h00;
            r_err       <= 1'b0;
            r_cnt       <= 16'd0;
            r_tcnt      <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_rnd_start <= w_rnd_start_nxt;
            r_captured  <= w_captured_nxt;
            r_err       <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tcnt      <= w_tcnt_nxt;
        end
    end

    assign bus_if.rnd_start  = r_rnd_start;
    assign bus_if.captured   = r_captured;
    assign bus_if.busy       = (r_state != S_IDLE);
    assign bus_if.delay_done = (r_state == S_DONE);
    assign bus_if.err        = r_err;

endmodule

// File: doc/random_delay_requester.md
# random_delay_requester

Requester side of the random-number start/ready handshake. Raises `rnd_start` toward the LFSR random generator and holds it until the generator reports ready. It then captures the 8-bit random value and converts it into a randomized wait of `(value << SHIFT) + MIN_DELAY` enable ticks. At the end of the wait it emits a one-clock `delay_done` pulse. Game/control logic uses it to obtain unpredictable delays; it shares `clk` and the `ena` tick with the generator.

## Interface
- `MIN_DELAY`, default 16: constant ticks added to every delay (0..255).
- `SHIFT`, default 0: left shift applied to the random value (0..7).
- `TIMEOUT`, default 64: maximum `ena` ticks to wait for ready before flagging an error (1..255).
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `ena` in 1: tick enable, the same strobe that drives the generator.
- `req` in 1: request a new random delay; sampled in IDLE only.
- `cancel` in 1: abort the current operation and return to IDLE.
- `rnd_value` in 8: random value from the generator.
- `rnd_rdy` in 1: generator ready flag.
- `rnd_start` out 1: start/run request to the generator (registered).
- `captured` out 8: last random value accepted.
- `busy` out 1: high in every state except IDLE.
- `delay_done` out 1: one-clock pulse at the end of the delay.
- `err` out 1: timeout flag; stays set until the next accepted `req` or reset.

## Operation
- States:
  - IDLE: on `req`=1 go to ARM and clear `err`.
  - ARM: `rnd_start`=1; wait for `rnd_rdy`=0. This rejects a ready flag left over from the previous run. When `rnd_rdy`=0, go to WAIT_RDY.
  - WAIT_RDY: `rnd_start`=1; when `rnd_rdy`=1, capture the value and load the counter, then go to DELAY (or DONE if the count is 0).
  - DELAY: `rnd_start`=0; decrement the counter on each `ena`.
  - DONE: `delay_done`=1, then go to IDLE.
- Counter is 16 bits, loaded with `(rnd_value << SHIFT) + MIN_DELAY`; no overflow is possible at the maximum parameters (255·128+255 < 2^16).
- Timeout counter is 8 bits. It is cleared on entry to ARM and counts `ena` ticks in ARM and WAIT_RDY. When it reaches `TIMEOUT`: set `err`, drop `rnd_start`, go to IDLE, and do not pulse `delay_done`.
- `cancel`=1 in any state: the next state is IDLE, `rnd_start`=0, no `delay_done`, `captured` is kept, `err` is unchanged. `cancel` has priority over `req`, `rnd_rdy` and the counter.
- `req` outside IDLE is ignored (not queued).
- `req` and `cancel` both high in IDLE: stay in IDLE.

## Timing
- Reset values: state IDLE, `rnd_start`=0, `captured`=0x00, `busy`=0, `delay_done`=0, `err`=0, counters 0.
- Reset asserted mid-operation: all outputs return to the reset values immediately (asynchronously), with no `delay_done` pulse.
- `req` sampled high at edge k: `busy` and `rnd_start` are high after edge k.
- If `rnd_rdy` is already 0, ARM lasts one clock.
- `rnd_rdy` sampled high at edge m in WAIT_RDY:
  - after edge m: `captured` = `rnd_value`@m and `rnd_start`=0.
  - `rnd_start` drops on the same edge that captures, so the generator freezes and `rnd_value` stays stable.
- DELAY with load N ≥ 1: the N-th `ena`-high edge moves to DONE. `delay_done` is high for exactly the one clock after that edge; `busy` falls the clock after.
- Load N = 0: DONE directly after edge m; `delay_done` is high in the clock after m.
- `ena`=0 cycles freeze both the delay and timeout counters.

## Test plan
- Basic run: MIN_DELAY=16, SHIFT=0, `ena`=1 constantly; a stub asserts `rnd_rdy` with `rnd_value`=0x05 after 3 clocks of `rnd_start` → `captured`=0x05, `delay_done` pulses 21 clocks after the capture edge, `busy` falls one clock later.
- Stale ready: `rnd_rdy` held at 1 when `req` arrives, drops after 2 clocks, rises again with 0x3C → the stale value is not captured, `captured`=0x3C.
- Zero delay: MIN_DELAY=0, `rnd_value`=0x00 → `delay_done` in the clock right after the capture edge.
- Timeout: TIMEOUT=8, `rnd_rdy` stuck at 0 → `err`=1 after 8 `ena` ticks, `rnd_start`=0, no `delay_done`; the next `req` clears `err`.
- Gated ticks: `ena` high every 4th clock, load 0x02 + MIN_DELAY=1, SHIFT=2 → 9 ticks, i.e. `delay_done` about 36 clocks after the capture edge.
- Abort: `cancel` in DELAY, and separately `rst`=0 in WAIT_RDY → IDLE, `rnd_start`=0, no `delay_done`. After reset all outputs are at their reset values; after cancel `captured` is kept.
